// File: rtl/holy_axi_reg_slice.sv
// rtl/holy_axi_reg_slice.sv - AXI4 register slice: two-entry skid buffer on AW, W, B, AR and R
//
// holy_axi_skid      : one channel; registered ready, main + skid payload registers.
// holy_axi_reg_slice : five skid channels between an upstream (s_axi_*) and downstream (m_axi_*) port.
//   clk, rst                : single clock, asynchronous active-high reset
//   s_axi_aw*/w*/ar*        : upstream forward channels (in), ready (out)
//   s_axi_b*/r*             : upstream reverse channels (out), ready (in)
//   m_axi_*                 : downstream mirror, directions reversed
//   wr_done_cnt, rd_done_cnt, resp_err_cnt : statistics, only with HOLY_AXI_SLICE_STATS_EN

module holy_axi_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         ready_q;
    logic         in_acc;
    logic         out_hs;

    assign in_acc = in_valid_i && ready_q;
    assign out_hs = main_valid_q && out_ready_i;

    always_comb begin
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            // ready is low while skid is occupied, so only the drain can happen
            if (out_hs) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_acc) begin
            if (!main_valid_q || out_ready_i) begin
                main_data_d  = in_data_i;
                main_valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data_i;
                skid_valid_d = 1'b1;
            end
        end else if (out_hs) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_q  <= '0;
            skid_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            // ready is a flop of the next skid state, so it stays low in reset
            ready_q      <= !skid_valid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
endmodule

module holy_axi_reg_slice #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
`ifdef HOLY_AXI_SLICE_STATS_EN
    ,
    output logic [31:0]             wr_done_cnt,
    output logic [31:0]             rd_done_cnt,
    output logic [31:0]             resp_err_cnt
`endif
);
    localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1;

    logic [AX_W-1:0] aw_out, ar_out;
    logic [W_W-1:0]  w_out;
    logic [B_W-1:0]  b_out;
    logic [R_W-1:0]  r_out;

    holy_axi_skid #(.W(AX_W)) u_aw (
        .clk(clk), .rst(rst),
        .in_valid_i(s_axi_awvalid), .in_ready_o(s_axi_awready),
        .in_data_i({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst}),
        .out_valid_o(m_axi_awvalid), .out_ready_i(m_axi_awready), .out_data_o(aw_out)
    );
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst} = aw_out;

    holy_axi_skid #(.W(W_W)) u_w (
        .clk(clk), .rst(rst),
        .in_valid_i(s_axi_wvalid), .in_ready_o(s_axi_wready),
        .in_data_i({s_axi_wdata, s_axi_wstrb, s_axi_wlast}),
        .out_valid_o(m_axi_wvalid), .out_ready_i(m_axi_wready), .out_data_o(w_out)
    );
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_out;

    holy_axi_skid #(.W(B_W)) u_b (
        .clk(clk), .rst(rst),
        .in_valid_i(m_axi_bvalid), .in_ready_o(m_axi_bready),
        .in_data_i({m_axi_bid, m_axi_bresp}),
        .out_valid_o(s_axi_bvalid), .out_ready_i(s_axi_bready), .out_data_o(b_out)
    );
    assign {s_axi_bid, s_axi_bresp} = b_out;

    holy_axi_skid #(.W(AX_W)) u_ar (
        .clk(clk), .rst(rst),
        .in_valid_i(s_axi_arvalid), .in_ready_o(s_axi_arready),
        .in_data_i({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst}),
        .out_valid_o(m_axi_arvalid), .out_ready_i(m_axi_arready), .out_data_o(ar_out)
    );
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} = ar_out;

    holy_axi_skid #(.W(R_W)) u_r (
        .clk(clk), .rst(rst),
        .in_valid_i(m_axi_rvalid), .in_ready_o(m_axi_rready),
        .in_data_i({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast}),
        .out_valid_o(s_axi_rvalid), .out_ready_i(s_axi_rready), .out_data_o(r_out)
    );
    assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_out;

`ifdef HOLY_AXI_SLICE_STATS_EN
    logic [31:0] wr_done_q, wr_done_d;
    logic [31:0] rd_done_q, rd_done_d;
    logic [31:0] resp_err_q, resp_err_d;
    logic        b_hs, r_last_hs;
    logic [1:0]  err_inc;

    // events are taken on the upstream side, i.e. when the core sees them
    assign b_hs      = s_axi_bvalid && s_axi_bready;
    assign r_last_hs = s_axi_rvalid && s_axi_rready && s_axi_rlast;
    assign err_inc   = {1'b0, b_hs && s_axi_bresp[1]} + {1'b0, r_last_hs && s_axi_rresp[1]};

    always_comb begin
        wr_done_d  = wr_done_q + {31'd0, b_hs};
        rd_done_d  = rd_done_q + {31'd0, r_last_hs};
        resp_err_d = resp_err_q + {30'd0, err_inc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_done_q  <= '0;
            rd_done_q  <= '0;
            resp_err_q <= '0;
        end else begin
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign wr_done_cnt  = wr_done_q;
    assign rd_done_cnt  = rd_done_q;
    assign resp_err_cnt = resp_err_q;
`endif
endmodule

// File: tb/tb_holy_axi_reg_slice.sv
// tb/tb_holy_axi_reg_slice.sv - self-checking bench for holy_axi_reg_slice
module tb_holy_axi_reg_slice;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  s_axi_awid = '0;   logic [31:0] s_axi_awaddr = '0; logic [7:0] s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = '0; logic [1:0]  s_axi_awburst = '0; logic s_axi_awvalid = 0; logic s_axi_awready;
    logic [31:0] s_axi_wdata = '0;  logic [3:0]  s_axi_wstrb = '0;  logic s_axi_wlast = 0;
    logic        s_axi_wvalid = 0;  logic        s_axi_wready;
    logic [3:0]  s_axi_bid;         logic [1:0]  s_axi_bresp;       logic s_axi_bvalid; logic s_axi_bready = 0;
    logic [3:0]  s_axi_arid = '0;   logic [31:0] s_axi_araddr = '0; logic [7:0] s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = '0; logic [1:0]  s_axi_arburst = '0; logic s_axi_arvalid = 0; logic s_axi_arready;
    logic [3:0]  s_axi_rid;         logic [31:0] s_axi_rdata;       logic [1:0] s_axi_rresp;
    logic        s_axi_rlast;       logic        s_axi_rvalid;      logic s_axi_rready = 0;
    logic [3:0]  m_axi_awid;        logic [31:0] m_axi_awaddr;      logic [7:0] m_axi_awlen;
    logic [2:0]  m_axi_awsize;      logic [1:0]  m_axi_awburst;     logic m_axi_awvalid; logic m_axi_awready = 0;
    logic [31:0] m_axi_wdata;       logic [3:0]  m_axi_wstrb;       logic m_axi_wlast;
    logic        m_axi_wvalid;      logic        m_axi_wready = 0;
    logic [3:0]  m_axi_bid = '0;    logic [1:0]  m_axi_bresp = '0;  logic m_axi_bvalid = 0; logic m_axi_bready;
    logic [3:0]  m_axi_arid;        logic [31:0] m_axi_araddr;      logic [7:0] m_axi_arlen;
    logic [2:0]  m_axi_arsize;      logic [1:0]  m_axi_arburst;     logic m_axi_arvalid; logic m_axi_arready = 0;
    logic [3:0]  m_axi_rid = '0;    logic [31:0] m_axi_rdata = '0;  logic [1:0] m_axi_rresp = '0;
    logic        m_axi_rlast = 0;   logic        m_axi_rvalid = 0;  logic m_axi_rready;
`ifdef HOLY_AXI_SLICE_STATS_EN
    logic [31:0] wr_done_cnt, rd_done_cnt, resp_err_cnt;
`endif

    holy_axi_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef HOLY_AXI_SLICE_STATS_EN
        , .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt), .resp_err_cnt(resp_err_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel view: 0=AW 1=W 2=B 3=AR 4=R, each as (input side) -> (output side)
    wire [63:0] aw_in  = 64'({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst});
    wire [63:0] aw_out = 64'({m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst});
    wire [63:0] w_in   = 64'({s_axi_wdata, s_axi_wstrb, s_axi_wlast});
    wire [63:0] w_out  = 64'({m_axi_wdata, m_axi_wstrb, m_axi_wlast});
    wire [63:0] b_in   = 64'({m_axi_bid, m_axi_bresp});
    wire [63:0] b_out  = 64'({s_axi_bid, s_axi_bresp});
    wire [63:0] ar_in  = 64'({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst});
    wire [63:0] ar_out = 64'({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst});
    wire [63:0] r_in   = 64'({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast});
    wire [63:0] r_out  = 64'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast});

    // Model: each channel is a 2-deep FIFO of accepted-but-not-delivered beats.
    typedef logic [63:0] pq_t[$];
    pq_t q[5];
    logic armed;
    int   cyc = 0;
    int   r_s_beats = 0;
    logic [31:0] exp_wr = 0, exp_rd = 0, exp_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) armed <= 1'b0;
        else     armed <= 1'b1;
    end
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [63:0] ip[5], op[5];
        logic        iv[5], ir[5], ov[5], orr[5];
        string       cn[5];
        cn = '{"aw", "w", "b", "ar", "r"};
        iv[0] = s_axi_awvalid; ir[0] = s_axi_awready; ov[0] = m_axi_awvalid; orr[0] = m_axi_awready; ip[0] = aw_in; op[0] = aw_out;
        iv[1] = s_axi_wvalid;  ir[1] = s_axi_wready;  ov[1] = m_axi_wvalid;  orr[1] = m_axi_wready;  ip[1] = w_in;  op[1] = w_out;
        iv[2] = m_axi_bvalid;  ir[2] = m_axi_bready;  ov[2] = s_axi_bvalid;  orr[2] = s_axi_bready;  ip[2] = b_in;  op[2] = b_out;
        iv[3] = s_axi_arvalid; ir[3] = s_axi_arready; ov[3] = m_axi_arvalid; orr[3] = m_axi_arready; ip[3] = ar_in; op[3] = ar_out;
        iv[4] = m_axi_rvalid;  ir[4] = m_axi_rready;  ov[4] = s_axi_rvalid;  orr[4] = s_axi_rready;  ip[4] = r_in;  op[4] = r_out;
        if (rst || !armed) begin
            for (int k = 0; k < 5; k++) begin
                chk({cn[k], "_valid_rst"}, 64'(ov[k]), 64'd0);
                chk({cn[k], "_ready_rst"}, 64'(ir[k]), 64'd0);
                q[k].delete();
            end
            exp_wr = 0; exp_rd = 0; exp_err = 0;
        end else begin
`ifdef HOLY_AXI_SLICE_STATS_EN
            chk("wr_done_cnt", 64'(wr_done_cnt), 64'(exp_wr));
            chk("rd_done_cnt", 64'(rd_done_cnt), 64'(exp_rd));
            chk("resp_err_cnt", 64'(resp_err_cnt), 64'(exp_err));
`endif
            if (s_axi_bvalid && s_axi_bready) begin
                exp_wr++;
                if (s_axi_bresp[1]) exp_err++;
            end
            if (s_axi_rvalid && s_axi_rready) begin
                r_s_beats++;
                if (s_axi_rlast) begin
                    exp_rd++;
                    if (s_axi_rresp[1]) exp_err++;
                end
            end
            for (int k = 0; k < 5; k++) begin
                chk({cn[k], "_valid"}, 64'(ov[k]), 64'(q[k].size() > 0));
                chk({cn[k], "_ready"}, 64'(ir[k]), 64'(q[k].size() < 2));
                if (q[k].size() > 0) chk({cn[k], "_payload"}, op[k], q[k][0]);
                if (ov[k] && orr[k] && q[k].size() > 0) void'(q[k].pop_front());
                if (iv[k] && ir[k]) q[k].push_back(ip[k]);
            end
        end
    end

    // Downstream W monitor for the directed burst checks
    logic [31:0] wseen_d[$];
    logic        wseen_l[$];
    int          wseen_c[$];
    always @(negedge clk) begin
        if (!rst && m_axi_wvalid && m_axi_wready) begin
            wseen_d.push_back(m_axi_wdata);
            wseen_l.push_back(m_axi_wlast);
            wseen_c.push_back(cyc);
        end
    end

    task automatic w_burst(input bit stall);
        int  i = 0, c = 0;
        bit  hs, saw_low = 0;
        wseen_d.delete(); wseen_l.delete(); wseen_c.delete();
        m_axi_wready = 1; s_axi_wvalid = 1; s_axi_wdata = 0; s_axi_wstrb = 4'hF; s_axi_wlast = 0;
        while (i < 8 && c < 100) begin
            @(negedge clk);
            hs = s_axi_wvalid && s_axi_wready;
            if (!s_axi_wready) saw_low = 1;
            @(posedge clk); #1;
            c++;
            if (hs) i++;
            if (i < 8) begin s_axi_wdata = 32'(i); s_axi_wlast = (i == 7); end
            else s_axi_wvalid = 0;
            m_axi_wready = !(stall && c >= 2 && c <= 5);
        end
        m_axi_wready = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("w_burst_timeout", 64'(c < 100), 64'd1);
        chk("w_burst_count", 64'(wseen_d.size()), 64'd8);
        for (int k = 0; k < 8 && k < wseen_d.size(); k++) begin
            chk("w_burst_data", 64'(wseen_d[k]), 64'(k));
            chk("w_burst_last", 64'(wseen_l[k]), 64'(k == 7));
        end
        if (stall) chk("w_stall_ready_drop", 64'(saw_low), 64'd1);
        else if (wseen_c.size() == 8) chk("w_back_to_back", 64'(wseen_c[7] - wseen_c[0]), 64'd7);
    endtask

    task automatic b_send(input logic [3:0] id, input logic [1:0] resp);
        int c = 0;
        bit hs = 0;
        m_axi_bvalid = 1; m_axi_bid = id; m_axi_bresp = resp; s_axi_bready = 1;
        while (!hs && c < 50) begin
            @(negedge clk); hs = m_axi_bvalid && m_axi_bready;
            @(posedge clk); #1; c++;
        end
        m_axi_bvalid = 0;
        chk("b_send_timeout", 64'(hs), 64'd1);
    endtask

    task automatic r_burst(input int len, input logic [1:0] last_resp);
        int c = 0;
        bit hs;
        s_axi_rready = 1;
        for (int k = 0; k < len; k++) begin
            m_axi_rvalid = 1; m_axi_rid = 4'(k); m_axi_rdata = 32'hA000 + 32'(k);
            m_axi_rlast = (k == len - 1); m_axi_rresp = (k == len - 1) ? last_resp : 2'd0;
            hs = 0;
            while (!hs && c < 100) begin
                @(negedge clk); hs = m_axi_rvalid && m_axi_rready;
                @(posedge clk); #1; c++;
            end
        end
        m_axi_rvalid = 0;
        chk("r_burst_timeout", 64'(c < 100), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, cnt, beats0;
        bit hs;

        // reset state and release
        @(negedge clk);
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_rdata",   64'(s_axi_rdata),   64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("pre_edge_wready", 64'(s_axi_wready), 64'd0);
        @(negedge clk);
        chk("post_edge_wready",  64'(s_axi_wready),  64'd1);
        chk("post_edge_awready", 64'(s_axi_awready), 64'd1);
        chk("post_edge_bready",  64'(m_axi_bready),  64'd1);
        chk("post_edge_rready",  64'(m_axi_rready),  64'd1);

        // single AR beat
        @(posedge clk); #1;
        m_axi_arready = 1; s_axi_arvalid = 1; s_axi_arid = 4'd3; s_axi_araddr = 32'h8000_0000;
        s_axi_arlen = 8'd0; s_axi_arsize = 3'd2; s_axi_arburst = 2'd1;
        @(negedge clk);
        chk("ar_not_yet", 64'(m_axi_arvalid), 64'd0);
        @(posedge clk); #1;
        s_axi_arvalid = 0;
        @(negedge clk);
        chk("ar_valid", 64'(m_axi_arvalid), 64'd1);
        chk("ar_addr",  64'(m_axi_araddr), 64'h8000_0000);
        chk("ar_id",    64'(m_axi_arid),   64'd3);
        chk("ar_ready", 64'(s_axi_arready), 64'd1);
        @(negedge clk);
        chk("ar_gone",  64'(m_axi_arvalid), 64'd0);

        // W bursts, free-flowing then stalled
        @(posedge clk); #1;
        w_burst(0);
        w_burst(1);

        // AW back-pressure, then reset mid-cycle with beats buffered
        m_axi_awready = 0; s_axi_awvalid = 1; s_axi_awaddr = 32'h100; s_axi_awid = 4'd1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk); hs = s_axi_awvalid && s_axi_awready;
            @(posedge clk); #1;
            if (hs) begin cnt++; s_axi_awaddr = s_axi_awaddr + 32'h10; end
        end
        @(negedge clk);
        chk("aw_accepted_two", 64'(cnt), 64'd2);
        chk("aw_bp_ready",     64'(s_axi_awready), 64'd0);
        chk("aw_held_addr",    64'(m_axi_awaddr),  64'h100);
        #2;
        rst = 1; s_axi_awvalid = 0; m_axi_awready = 1;
        #1;
        chk("midrst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("midrst_awready", 64'(s_axi_awready), 64'd0);
        chk("midrst_wready",  64'(s_axi_wready),  64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // responses for statistics: B resp 0,2,0 and two R bursts ending resp 0,3
        b_send(4'd1, 2'd0);
        b_send(4'd2, 2'd2);
        b_send(4'd3, 2'd0);
        r_burst(3, 2'd0);
        r_burst(2, 2'd3);
        repeat (3) @(posedge clk);
        #1;
`ifdef HOLY_AXI_SLICE_STATS_EN
        @(negedge clk);
        chk("stat_wr_lit",  64'(wr_done_cnt),  64'd3);
        chk("stat_rd_lit",  64'(rd_done_cnt),  64'd2);
        chk("stat_err_lit", 64'(resp_err_cnt), 64'd2);
        @(posedge clk); #1;
`endif

        // long random R traffic with AXI-legal source hold
        idx = 0; cnt = 0; beats0 = r_s_beats;
        m_axi_rvalid = 0;
        while (idx < 1000 && cnt < 20000) begin
            @(negedge clk); hs = m_axi_rvalid && m_axi_rready;
            @(posedge clk); #1; cnt++;
            if (hs) idx++;
            if (!m_axi_rvalid || hs) begin
                if (idx < 1000 && $urandom_range(0, 9) < 7) begin
                    m_axi_rvalid = 1; m_axi_rid = 4'(idx); m_axi_rdata = 32'(idx) * 32'h9E37_79B1;
                    m_axi_rresp = 2'(idx); m_axi_rlast = (idx % 4 == 3);
                end else m_axi_rvalid = 0;
            end
            s_axi_rready = ($urandom_range(0, 9) < 6);
        end
        m_axi_rvalid = 0; s_axi_rready = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("r_rand_sent",      64'(idx), 64'd1000);
        chk("r_rand_delivered", 64'(r_s_beats - beats0), 64'd1000);

`ifdef HOLY_AXI_SLICE_STATS_EN
        // counter wrap
        @(negedge clk);
        dut.wr_done_q = 32'hFFFF_FFFF;
        exp_wr = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        b_send(4'd5, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stat_wr_wrap", 64'(wr_done_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/holy_axi_reg_slice.md
# holy_axi_reg_slice

Parametrised AXI4 full register slice placed between the HOLY core's AXI master port and the system interconnect. It breaks every combinational path on all five channels (AW, W, B, AR, R) with a two-entry skid buffer per channel. Transfers pass one-for-one, in order, at full throughput, adding exactly one cycle of latency per direction. Widths are generic, so the same block serves the 32-bit core bus and wider DMA or cache buses.

## Interface
- ADDR_WIDTH, 32, address width of AW/AR
- DATA_WIDTH, 32, data width of W/R; multiple of 8
- ID_WIDTH, 4, transaction ID width on AW/B/AR/R
- clk  in  1  single clock for both sides
- rst  in  1  asynchronous, active-high reset
- s_axi_aw{id,addr,len,size,burst}, s_axi_awvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2, 1  upstream write address
- s_axi_awready  out  1
- s_axi_w{data,strb,last}, s_axi_wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1, 1  upstream write data
- s_axi_wready  out  1
- s_axi_b{id,resp}, s_axi_bvalid  out  ID_WIDTH/2, 1  upstream write response
- s_axi_bready  in  1
- s_axi_ar{id,addr,len,size,burst}, s_axi_arvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2, 1  upstream read address
- s_axi_arready  out  1
- s_axi_r{id,data,resp,last}, s_axi_rvalid  out  ID_WIDTH/DATA_WIDTH/2/1, 1  upstream read data
- s_axi_rready  in  1
- m_axi_*  mirror of s_axi_* with directions reversed, same widths; downstream side
- wr_done_cnt, rd_done_cnt, resp_err_cnt  out  32 each  statistics; present only with HOLY_AXI_SLICE_STATS_EN

## Operation
- Each channel has an identical skid buffer: a main register (payload plus main_valid) that drives the output, and a skid register (payload plus skid_valid).
- Input ready is registered, equal to !skid_valid.
- Input accepted (valid && ready), output empty or draining: the beat loads into main.
- Input accepted while main holds a beat that is stalled (out_valid && !out_ready): the beat loads into skid, and ready drops next cycle.
- Output handshake with skid_valid set: skid moves to main, skid_valid clears, and ready rises next cycle.
- Output handshake with skid empty and a simultaneous input accept: the new beat loads into main (no bubble).
- Output payload is held stable while out_valid && !out_ready.
- Order is strictly FIFO within each channel. No beat is dropped or duplicated.
- Channels are independent; no AW/W or AR/R coupling is imposed (AXI rules).
- Forward channels (AW, W, AR) run s to m. Reverse channels (B, R) run m to s.
- Fields are copied bit-exact; the slice performs no decode or modification.

## Timing
- Latency: input handshake at edge N gives output valid after edge N, i.e. visible in cycle N+1.
- Throughput: one beat per cycle per channel when the output is never stalled.
- Buffer: 2 beats per channel. The third stalled beat is back-pressured.
- Reset, while rst is high (asynchronous):
  - all *valid outputs are 0;
  - all *ready outputs are 0;
  - payload registers are 0;
  - counters are 0.
- First edge after rst falls: all readies go to 1.
- Reset mid-burst: buffered beats are discarded. Recovery of the protocol is the responsibility of the system; both sides are reset together.
- Combinational paths from input to output: none on any channel.

## Configuration
- HOLY_AXI_SLICE_STATS_EN defined: the three 32-bit counters are built and ported.
  - wr_done_cnt increments on each s-side B handshake.
  - rd_done_cnt increments on each s-side R handshake with rlast=1.
  - resp_err_cnt increments on a B handshake or an R-last handshake with resp[1]=1.
  - B and R error events in the same cycle add 2.
  - All counters wrap from 0xFFFFFFFF to 0.
- HOLY_AXI_SLICE_STATS_EN undefined: no counters and no counter ports; datapath behaviour is identical.

## Test plan
- Reset pulse mid-cycle → all valids and readies read 0 immediately; readies are 1 one edge after release.
- AR beat (id=3, addr=0x80000000, len=0), m_arready held 1 → m_arvalid high one cycle later with identical fields; no ready drop.
- 8-beat W burst (data 0x0..0x7, last on beat 7), m_wready=1 → eight consecutive m_w beats, same order, wlast only on 0x7.
- Same W burst with m_wready=0 for cycles 2–5 → s_wready falls after 2 beats are buffered; no loss or duplication; output order 0x0..0x7.
- R burst with random m_rvalid/s_rready toggling over 1000 beats → scoreboard shows exact in-order match and output payload stable during stalls.
- STATS_EN: 3 B responses (resp=0,2,0) and 2 R bursts (last resp=0,3) → wr_done_cnt=3, rd_done_cnt=2, resp_err_cnt=2. Preload to 0xFFFFFFFF plus 1 event → counter reads 0.
